// File: rtl/decode_prefix_sequencer_pkg.sv
// ============================================================================
// decode_prefix_sequencer_pkg : shared encodings for the decode prefix sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package decode_prefix_sequencer_pkg;

  // Sequencer state encodings, also used by decode-stage observers.
  typedef enum logic [1:0] {
    DEC_SEQ_PREFIX = 2'd0,
    DEC_SEQ_ISSUE  = 2'd1,
    DEC_SEQ_FAULT  = 2'd2
  } dec_seq_state_e;

  localparam int INSTR_MAX_LEN = 15;

  // Prefixes plus body must fit the architectural limit; summed at 5 bits so
  // the largest 4-bit operands cannot wrap.
  function automatic logic len_exceeds(input logic [3:0] prefix_count,
                                       input logic [3:0] instr_len,
                                       input logic [4:0] limit);
    logic [4:0] sum;
    sum = {1'b0, prefix_count} + {1'b0, instr_len};
    return sum > limit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_prefix_sequencer.sv
// ============================================================================
// decode_prefix_sequencer : consumes prefix bytes one per cycle, issues the
// instruction body to micro and raises #GP on the 15-byte length limit.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module decode_prefix_sequencer
  import decode_prefix_sequencer_pkg::*;
#(
  parameter int MAX_LEN = INSTR_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_reset,
  input  logic [3:0] fetch_valid,
  input  logic       is_prefix,
  input  logic [3:0] prefix_count,
  input  logic [3:0] instr_len,
  input  logic       instr_len_valid,
  input  logic       micro_ready,
  output logic       instr_prefix,
  output logic       instr_finished,
  output logic       fetch_accept_do,
  output logic [3:0] fetch_accept_length,
  output logic       dec_ready,
  output logic [3:0] dec_length,
  output logic       dec_fault_gp
);

  localparam logic [4:0] LIMIT       = 5'(MAX_LEN);
  localparam logic [3:0] LAST_PREFIX = 4'(MAX_LEN - 1);

  dec_seq_state_e state_q;
  dec_seq_state_e state_d;
  logic [3:0]     length_d;
  logic           prefix_c;
  logic           finished_c;
  logic           accept_c;
  logic [3:0]     accept_len_c;

  always_comb begin
    state_d      = state_q;
    length_d     = dec_length;
    prefix_c     = 1'b0;
    finished_c   = 1'b0;
    accept_c     = 1'b0;
    accept_len_c = 4'd0;

    unique case (state_q)
      DEC_SEQ_PREFIX: begin
        if (fetch_valid != 4'd0) begin
          if (is_prefix) begin
            // One more prefix would push past the limit: fault without consuming.
            if (prefix_count == LAST_PREFIX) begin
              state_d = DEC_SEQ_FAULT;
            end else begin
              prefix_c     = 1'b1;
              accept_c     = 1'b1;
              accept_len_c = 4'd1;
            end
          end else if (instr_len_valid && (instr_len != 4'd0)) begin
            if (len_exceeds(prefix_count, instr_len, LIMIT)) begin
              state_d = DEC_SEQ_FAULT;
            end else if (fetch_valid >= instr_len) begin
              state_d  = DEC_SEQ_ISSUE;
              length_d = instr_len;
            end
          end
        end
      end
      DEC_SEQ_ISSUE: begin
        if (micro_ready) begin
          accept_c     = 1'b1;
          accept_len_c = dec_length;
          finished_c   = 1'b1;
          state_d      = DEC_SEQ_PREFIX;
        end
      end
      DEC_SEQ_FAULT: begin
        state_d = DEC_SEQ_FAULT;
      end
      default: begin
        state_d = DEC_SEQ_PREFIX;
      end
    endcase

    // Flush overrides everything and drops any in-flight instruction.
    if (dec_reset) begin
      state_d      = DEC_SEQ_PREFIX;
      length_d     = dec_length;
      prefix_c     = 1'b0;
      accept_c     = 1'b0;
      accept_len_c = 4'd0;
      finished_c   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DEC_SEQ_PREFIX;
      dec_ready    <= 1'b0;
      dec_length   <= 4'd0;
      dec_fault_gp <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_ready    <= (state_d == DEC_SEQ_ISSUE);
      dec_length   <= length_d;
      dec_fault_gp <= (state_d == DEC_SEQ_FAULT);
    end
  end

  // Strobes are combinational, so hold them quiet while reset is asserted.
  assign instr_prefix        = rst_n & prefix_c;
  assign instr_finished      = rst_n & finished_c;
  assign fetch_accept_do     = rst_n & accept_c;
  assign fetch_accept_length = rst_n ? accept_len_c : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_decode_prefix_sequencer.sv
// ============================================================================
// tb_decode_prefix_sequencer : cycle-by-cycle directed vectors for the sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_decode_prefix_sequencer;

  logic       clk;
  logic       rst_n;
  logic       dec_reset;
  logic [3:0] fetch_valid;
  logic       is_prefix;
  logic [3:0] prefix_count;
  logic [3:0] instr_len;
  logic       instr_len_valid;
  logic       micro_ready;
  logic       instr_prefix;
  logic       instr_finished;
  logic       fetch_accept_do;
  logic [3:0] fetch_accept_length;
  logic       dec_ready;
  logic [3:0] dec_length;
  logic       dec_fault_gp;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  decode_prefix_sequencer #(.MAX_LEN(15)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dec_reset           (dec_reset),
    .fetch_valid         (fetch_valid),
    .is_prefix           (is_prefix),
    .prefix_count        (prefix_count),
    .instr_len           (instr_len),
    .instr_len_valid     (instr_len_valid),
    .micro_ready         (micro_ready),
    .instr_prefix        (instr_prefix),
    .instr_finished      (instr_finished),
    .fetch_accept_do     (fetch_accept_do),
    .fetch_accept_length (fetch_accept_length),
    .dec_ready           (dec_ready),
    .dec_length          (dec_length),
    .dec_fault_gp        (dec_fault_gp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: inputs driven, plus the outputs expected in that same cycle
  // (Mealy strobes, and the registered outputs as currently presented).
  typedef struct packed {
    logic       rst;
    logic [3:0] fv;
    logic       pfx;
    logic [3:0] pc;
    logic [3:0] len;
    logic       lv;
    logic       mr;
    logic       e_ip;
    logic       e_fin;
    logic       e_acc;
    logic [3:0] e_alen;
    logic       e_rdy;
    logic [3:0] e_dlen;
    logic       e_gp;
  } vec_t;

  function automatic vec_t vv(logic rst, logic [3:0] fv, logic pfx, logic [3:0] pc,
                              logic [3:0] len, logic lv, logic mr,
                              logic ip, logic fin, logic acc, logic [3:0] alen,
                              logic rdy, logic [3:0] dlen, logic gp);
    vec_t v;
    v.rst = rst; v.fv = fv; v.pfx = pfx; v.pc = pc; v.len = len; v.lv = lv; v.mr = mr;
    v.e_ip = ip; v.e_fin = fin; v.e_acc = acc; v.e_alen = alen;
    v.e_rdy = rdy; v.e_dlen = dlen; v.e_gp = gp;
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d %s: got %0d expected %0d", tag, step_no, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_reset       = v.rst;
    fetch_valid     = v.fv;
    is_prefix       = v.pfx;
    prefix_count    = v.pc;
    instr_len       = v.len;
    instr_len_valid = v.lv;
    micro_ready     = v.mr;
  endtask

  // Entered just after a rising edge; checks on the falling edge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk(tag, "instr_prefix", int'(instr_prefix), int'(v.e_ip));
    chk(tag, "instr_finished", int'(instr_finished), int'(v.e_fin));
    chk(tag, "fetch_accept_do", int'(fetch_accept_do), int'(v.e_acc));
    if (v.e_acc) chk(tag, "fetch_accept_length", int'(fetch_accept_length), int'(v.e_alen));
    chk(tag, "dec_ready", int'(dec_ready), int'(v.e_rdy));
    if (v.e_rdy) chk(tag, "dec_length", int'(dec_length), int'(v.e_dlen));
    chk(tag, "dec_fault_gp", int'(dec_fault_gp), int'(v.e_gp));
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "instr_prefix", int'(instr_prefix), 0);
    chk(tag, "instr_finished", int'(instr_finished), 0);
    chk(tag, "fetch_accept_do", int'(fetch_accept_do), 0);
    chk(tag, "dec_ready", int'(dec_ready), 0);
    chk(tag, "dec_fault_gp", int'(dec_fault_gp), 0);
  endtask

  vec_t tbl[23];

  initial begin
    //            rst fv pfx pc len lv mr | ip fin acc alen rdy dlen gp
    tbl[0]  = vv(0, 8, 1, 0,  0,  0, 1,  1, 0, 1, 1, 0, 0, 0); // 66
    tbl[1]  = vv(0, 8, 1, 1,  0,  0, 1,  1, 0, 1, 1, 0, 0, 0); // 2E
    tbl[2]  = vv(0, 8, 0, 2,  3,  1, 1,  0, 0, 0, 0, 0, 0, 0); // body decision
    tbl[3]  = vv(0, 8, 0, 2,  3,  1, 1,  0, 1, 1, 3, 1, 3, 0); // issue + accept 3
    tbl[4]  = vv(0, 0, 1, 0,  0,  0, 1,  0, 0, 0, 0, 0, 0, 0); // empty queue
    tbl[5]  = vv(0, 8, 0, 0,  5,  0, 1,  0, 0, 0, 0, 0, 0, 0); // len not valid
    tbl[6]  = vv(0, 8, 0, 0,  0,  1, 1,  0, 0, 0, 0, 0, 0, 0); // len zero
    tbl[7]  = vv(0, 8, 0, 12, 4,  1, 1,  0, 0, 0, 0, 0, 0, 0); // sum 16 -> fault
    tbl[8]  = vv(0, 8, 1, 12, 0,  0, 1,  0, 0, 0, 0, 0, 0, 1); // fault holds
    tbl[9]  = vv(1, 8, 1, 12, 0,  0, 1,  0, 1, 0, 0, 0, 0, 1); // flush in fault
    tbl[10] = vv(0, 8, 0, 12, 3,  1, 0,  0, 0, 0, 0, 0, 0, 0); // sum 15 -> issue
    tbl[11] = vv(0, 8, 0, 12, 3,  1, 0,  0, 0, 0, 0, 1, 3, 0); // waiting on micro
    tbl[12] = vv(1, 8, 0, 12, 3,  1, 1,  0, 1, 0, 0, 1, 3, 0); // flush in issue
    tbl[13] = vv(0, 8, 0, 0,  15, 1, 1,  0, 0, 0, 0, 0, 0, 0); // starved for 15
    tbl[14] = vv(1, 8, 1, 0,  0,  0, 1,  0, 1, 0, 0, 0, 0, 0); // flush over prefix
    tbl[15] = vv(0, 8, 1, 14, 0,  0, 1,  0, 0, 0, 0, 0, 0, 0); // 15th prefix -> fault
    tbl[16] = vv(0, 8, 0, 14, 3,  1, 1,  0, 0, 0, 0, 0, 0, 1); // no accept in fault
    tbl[17] = vv(1, 8, 0, 14, 3,  1, 1,  0, 1, 0, 0, 0, 0, 1); // flush
    tbl[18] = vv(0, 8, 1, 13, 0,  0, 1,  1, 0, 1, 1, 0, 0, 0); // 14th prefix ok
    tbl[19] = vv(0, 1, 0, 14, 1,  1, 1,  0, 0, 0, 0, 0, 0, 0); // sum 15, body 1
    tbl[20] = vv(0, 0, 0, 14, 1,  1, 1,  0, 1, 1, 1, 1, 1, 0); // fv ignored in issue
    tbl[21] = vv(0, 8, 0, 0,  8,  1, 0,  0, 0, 0, 0, 0, 0, 0); // body 8
    tbl[22] = vv(0, 8, 0, 0,  8,  1, 1,  0, 1, 1, 8, 1, 8, 0);

    // Reset with stimulus that would otherwise fire every strobe.
    rst_n = 1'b0;
    drive(vv(1, 8, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #12;
    chk_all_zero("reset");
    chk("reset", "dec_length", int'(dec_length), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) step(tbl[i], "table");

    // Fourteen prefixes are legal, the fifteenth faults without consuming.
    for (int i = 0; i < 14; i++)
      step(vv(0, 8, 1, 4'(i), 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), "prefix14");
    step(vv(0, 8, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "prefix15");
    step(vv(0, 8, 1, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "prefix15_gp");
    step(vv(1, 8, 1, 14, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1), "prefix15_flush");

    // Starvation then backpressure.
    for (int i = 0; i < 3; i++)
      step(vv(0, 4, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0), "starve");
    step(vv(0, 6, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0), "starve_fill");
    for (int i = 0; i < 5; i++)
      step(vv(0, 4'(i), 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 6, 0), "backpressure");
    step(vv(0, 3, 0, 0, 6, 1, 1, 0, 1, 1, 6, 1, 6, 0), "bp_release");

    // Asynchronous reset after two prefixes, mid-cycle with a prefix present.
    step(vv(0, 8, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), "areset_pfx");
    step(vv(0, 8, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), "areset_pfx");
    drive(vv(0, 8, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("areset_now");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(vv(0, 8, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), "restart_pfx");
    step(vv(0, 8, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "restart_body");
    step(vv(0, 8, 0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 2, 0), "restart_wait");

    // Asynchronous reset while presenting drops the instruction.
    drive(vv(0, 8, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("areset_issue");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(vv(0, 8, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0), "after_areset");
    step(vv(0, 8, 0, 0, 2, 1, 1, 0, 1, 1, 2, 1, 2, 0), "after_areset_issue");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_prefix_sequencer.md
# decode_prefix_sequencer

Sequences consumption of instruction bytes in the decode stage, one prefix byte per cycle, then hands the complete instruction body to the micro stage. It drives the prefix decoder's `instr_prefix` / `instr_finished` strobes and returns accepted byte counts to the fetch queue. It enforces the 15-byte x86 instruction-length limit by raising a #GP fault request, and it clears prefix state on pipeline flush. It sits in the decode stage, beside the prefix decoder and between fetch and micro.

## Interface
Parameters:
- `MAX_LEN`, default 15: architectural instruction-length limit in bytes.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `dec_reset` in 1: pipeline flush, synchronous, highest priority.
- `fetch_valid` in 4: valid bytes at the fetch-queue head, 0..8.
- `is_prefix` in 1: head byte is F2/F3/F0/26/2E/36/3E/64/65/66/67/0F; comes from the prefix decoder, combinational.
- `prefix_count` in 4: prefixes already consumed for the current instruction; comes from the prefix decoder.
- `instr_len` in 4: length of the non-prefix body (opcode through immediate), 1..15.
- `instr_len_valid` in 1: `instr_len` is meaningful for the head byte.
- `micro_ready` in 1: micro stage accepts the presented instruction this cycle.
- `instr_prefix` out 1: consume one prefix byte; strobe to the prefix decoder.
- `instr_finished` out 1: clear prefix state; strobe to the prefix decoder.
- `fetch_accept_do` out 1: the fetch queue drops `fetch_accept_length` bytes.
- `fetch_accept_length` out 4: bytes consumed this cycle.
- `dec_ready` out 1: instruction presented to micro.
- `dec_length` out 4: presented body length.
- `dec_fault_gp` out 1: length-limit violation, held until flush.

## Operation
- States:
  - `S_PREFIX` = 0: scan the head byte.
  - `S_ISSUE` = 1: present the instruction.
  - `S_FAULT` = 2: fault latched.
- `S_PREFIX`, evaluated in this priority order:
  - `fetch_valid == 0`: hold, no strobes.
  - `is_prefix && prefix_count == MAX_LEN-1`: go to `S_FAULT`; no byte consumed.
  - `is_prefix`: assert `instr_prefix`, `fetch_accept_do`, and `fetch_accept_length` = 1; stay in `S_PREFIX`.
  - `!is_prefix && instr_len_valid && instr_len != 0`, with sum = {1'b0, `prefix_count`} + {1'b0, `instr_len`} computed at 5 bits:
    - sum > `MAX_LEN`: go to `S_FAULT`.
    - else if `fetch_valid` >= `instr_len`: capture `dec_length` <= `instr_len` and go to `S_ISSUE`.
    - else stall in `S_PREFIX`.
  - `instr_len_valid` = 0 or `instr_len` = 0: stall.
- `S_ISSUE`:
  - `dec_ready` = 1.
  - On `micro_ready`: assert `fetch_accept_do`, `fetch_accept_length` = `dec_length`, and `instr_finished`; go to `S_PREFIX`.
- `S_FAULT`:
  - `dec_fault_gp` = 1.
  - No fetch accepts; exit only via `dec_reset` or `rst_n`.
- `dec_reset`, in any state:
  - Next state is `S_PREFIX`; `dec_ready` and `dec_fault_gp` go to 0.
  - `instr_finished` = 1 in that cycle, which clears the prefix decoder.
  - `fetch_accept_do` = 0 and `instr_prefix` = 0 in that cycle, even if `micro_ready` or a prefix is present.
- `instr_finished` = (`S_ISSUE` && `micro_ready` && !`dec_reset`) || `dec_reset`.
- 0F counts as a prefix byte toward the limit, consistent with `prefix_count`.

## Timing
- Reset values:
  - state = `S_PREFIX`.
  - `dec_ready` = 0, `dec_length` = 0, `dec_fault_gp` = 0.
  - All strobes are 0 while `rst_n` = 0.
- `instr_prefix`, `instr_finished`, `fetch_accept_do`, and `fetch_accept_length` are Mealy outputs, same cycle as their inputs. The prefix decoder samples them on the next edge.
- `dec_ready`, `dec_length`, and `dec_fault_gp` are registered (Moore).
- Prefix throughput: 1 byte per cycle.
- Body: decision in cycle N, `dec_ready` in N+1, earliest accept in N+1, next scan in N+2.
- `dec_length` is stable while `dec_ready` = 1. `fetch_valid` changes during `S_ISSUE` are ignored.
- Reset mid-`S_ISSUE` drops the instruction with no partial accept.

## Structure
- Add to ao486-defines:
  - State encodings `DEC_SEQ_PREFIX`, `DEC_SEQ_ISSUE`, `DEC_SEQ_FAULT`, 2 bits each.
  - `INSTR_MAX_LEN` = 15.
- No sub-module. The block is a single FSM plus a 5-bit length adder/comparator, instantiated next to the prefix decoder in the decode stage.

## Test plan
- Prefix sequence: bytes 66, 2E, then body length 3, `fetch_valid` = 8, `micro_ready` = 1.
  - Required: `instr_prefix` in cycles 0–1.
  - `dec_ready` and `dec_length` = 3 in cycle 3.
  - Accept of 3 bytes with `instr_finished` in cycle 3.
- Length-limit fault:
  - 14 prefixes then a prefix byte: `dec_fault_gp` = 1 on the next cycle, no accept.
  - Separately, `prefix_count` = 12 with `instr_len` = 4 (sum 16): fault. `instr_len` = 3 (sum 15): issue.
- Starvation: `instr_len` = 6 with `fetch_valid` = 4 for 3 cycles, then 6.
  - Required: no `dec_ready` while starved; `dec_ready` one cycle after `fetch_valid` reaches 6.
- Backpressure: `micro_ready` = 0 for 5 cycles in `S_ISSUE`.
  - Required: `dec_ready` held, `dec_length` constant, no `fetch_accept_do` until `micro_ready` rises.
- Flush:
  - `dec_reset` with `micro_ready` in `S_ISSUE`: `instr_finished` = 1, `fetch_accept_do` = 0, next state `S_PREFIX`.
  - `dec_reset` in `S_FAULT`: `dec_fault_gp` = 0 on the next cycle.
- Async reset mid-prefix: assert `rst_n` = 0 after 2 prefixes.
  - Required: all outputs 0 immediately; clean restart scanning from `S_PREFIX`.
